// File: rtl/jt12_cic_integ.sv
// Interpolating half of the JT12 CIC chain: zero-stuffs comb samples from the
// input rate up to the output rate, runs n wrap-around integrators on cen_out,
// then shifts and saturates into a strobed output sample.
module jt12_cic_integ #(
  parameter int w_in  = 16,
  parameter int w_out = 16,
  parameter int n     = 2,
  parameter int g     = 4,
  parameter int shift = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen_in,
  input  logic                    cen_out,
  input  logic signed [w_in-1:0]  snd_in,
  output logic signed [w_out-1:0] snd_out,
  output logic                    snd_stb,
  output logic                    overrun
);

  localparam int wi = w_in + g;

  // Refuse parameter sets where the scaled integrator cannot cover the output range.
  if (w_in + g < w_out + shift) begin : g_width_chk
    $error("jt12_cic_integ: w_in+g must be >= w_out+shift");
  end
  if (n < 1 || n > 4) begin : g_stage_chk
    $error("jt12_cic_integ: n must be in 1..4");
  end
  if (shift < 0 || shift > g) begin : g_shift_chk
    $error("jt12_cic_integ: shift must be in 0..g");
  end

  // Output clamp limits expressed at integrator width.
  localparam logic signed [wi-1:0] c_max = {{(wi-w_out+1){1'b0}}, {(w_out-1){1'b1}}};
  localparam logic signed [wi-1:0] c_min = {{(wi-w_out+1){1'b1}}, {(w_out-1){1'b0}}};

  logic signed [w_in-1:0]  r_pend_data;
  logic                    r_pend_flag;
  logic signed [wi-1:0]    r_integ [n];
  logic signed [w_out-1:0] r_snd_out;
  logic                    r_snd_stb;
  logic                    r_overrun;

  logic signed [w_in-1:0]  w_x;
  logic signed [wi-1:0]    w_x_ext;
  logic signed [wi-1:0]    w_t;
  logic signed [w_out-1:0] w_sat;

  // Pick the stuffed value: same-cycle input bypasses, else pending sample, else zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_x = '0;
    if (cen_in) begin
      w_x = snd_in;
    end else if (r_pend_flag) begin
      w_x = r_pend_data;
    end
  end

  assign w_x_ext = wi'(w_x);
  assign w_t     = r_integ[n-1] >>> shift;

  // Clamp the scaled last-stage value into the signed output range.
  always_comb begin
    w_sat = w_t[w_out-1:0];
    if (w_t > c_max) begin
      w_sat = c_max[w_out-1:0];
    end else if (w_t < c_min) begin
      w_sat = c_min[w_out-1:0];
    end
  end

  // Input capture, integrator cascade and output register, all with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage read its pre-strobe neighbour.
    if (!rst_n) begin
      r_pend_data <= '0;
      r_pend_flag <= 1'b0;
      // NOTE: the integrators are cleared explicitly; they hold the filter history,
      // so an unreset value would bias every following output sample.
      for (int k = 0; k < n; k++) begin
        r_integ[k] <= '0;
      end
      r_snd_out   <= '0;
      r_snd_stb   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_snd_stb <= cen_out;
      if (cen_out) begin
        r_pend_flag <= 1'b0;
        r_integ[0]  <= r_integ[0] + w_x_ext;
        for (int k = 1; k < n; k++) begin
          r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
        r_snd_out <= w_sat;
      end else if (cen_in) begin
        r_pend_data <= snd_in;
        r_pend_flag <= 1'b1;
        if (r_pend_flag) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign snd_out = r_snd_out;
  assign snd_stb = r_snd_stb;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_jt12_cic_integ.sv
// Bench for jt12_cic_integ: one n=2 and one n=1 instance share the stimulus.
// The model keeps the list of stuffed samples and computes each output as a
// binomially weighted sum of that history, wrapped to the integrator width.
module tb_jt12_cic_integ;

  localparam int wi = 20;

  logic clk = 1'b0;
  logic rst_n, cen_in, cen_out;
  logic signed [15:0] snd_in;
  logic signed [15:0] out2, out1;
  logic stb2, stb1, ovr2, ovr1;

  jt12_cic_integ #(.w_in(16), .w_out(16), .n(2), .g(4), .shift(0)) dut (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .cen_out(cen_out),
    .snd_in(snd_in), .snd_out(out2), .snd_stb(stb2), .overrun(ovr2));

  jt12_cic_integ #(.w_in(16), .w_out(16), .n(1), .g(4), .shift(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .cen_out(cen_out),
    .snd_in(snd_in), .snd_out(out1), .snd_stb(stb1), .overrun(ovr1));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int     hist[$];
  int     pend_q[$];
  bit     m_ovr;
  bit     m_stb;
  longint m_out2, m_out1;

  function automatic longint binom(input int a, input int b);
    longint r = 1;
    if (a < b) return 0;
    for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
    return r;
  endfunction

  // Output of an nn-stage chain at the next strobe: sum_j C(k-1-j, nn-1) * x_j,
  // taken modulo 2^wi, then clamped to 16 bits signed.
  function automatic longint model_out(input int nn);
    longint acc = 0;
    int k = hist.size();
    for (int j = 0; j < k; j++) acc += binom(k - 1 - j, nn - 1) * longint'(hist[j]);
    acc = acc & ((longint'(1) << wi) - 1);
    if (acc >= (longint'(1) << (wi - 1))) acc -= (longint'(1) << wi);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  always @(posedge clk) begin
    int x;
    if (!rst_n) begin
      hist.delete();
      pend_q.delete();
      m_ovr  = 1'b0;
      m_stb  = 1'b0;
      m_out2 = 0;
      m_out1 = 0;
    end else begin
      m_stb = cen_out;
      if (cen_out) begin
        m_out2 = model_out(2);
        m_out1 = model_out(1);
        if (cen_in)                x = int'(snd_in);
        else if (pend_q.size() > 0) x = pend_q[0];
        else                       x = 0;
        pend_q.delete();
        hist.push_back(x);
      end else if (cen_in) begin
        if (pend_q.size() > 0) m_ovr = 1'b1;
        pend_q.delete();
        pend_q.push_back(int'(snd_in));
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      check("snd_out_n2", longint'(out2), m_out2);
      check("snd_out_n1", longint'(out1), m_out1);
      check("snd_stb_n2", longint'(stb2), longint'(m_stb));
      check("snd_stb_n1", longint'(stb1), longint'(m_stb));
      check("overrun_n2", longint'(ovr2), longint'(m_ovr));
      check("overrun_n1", longint'(ovr1), longint'(m_ovr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit ci, input bit co, input int d);
    cen_in  = ci;
    cen_out = co;
    snd_in  = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cen_in = 1'b0; cen_out = 1'b0; snd_in = '0;

    // Reset / idle
    do_reset();
    armed = 1'b1;
    check("reset_out", longint'(out2), 0);
    check("reset_ovr", longint'(ovr2), 0);
    check("reset_stb", longint'(stb2), 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    check("idle_out", longint'(out2), 0);
    check("idle_stb", longint'(stb2), 1);

    // Impulse, n=2: outputs 0,0,1,2,3,4,...
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(i % 4 == 0, 1, (i == 0) ? 1 : 0);
      if (i == 1) check("impulse_s1", longint'(out2), 0);
      if (i == 2) check("impulse_s2", longint'(out2), 1);
      if (i == 5) check("impulse_s5", longint'(out2), 4);
    end

    // DC reconstruction, n=1
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(i % 4 == 0, 1, (i == 0) ? 1000 : 0);
      if (i == 0) check("dc_s0", longint'(out1), 0);
      if (i == 6) check("dc_s6", longint'(out1), 1000);
    end

    // Positive saturation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(i % 4 == 0, 1, 32767);
      if (i == 3) check("sat_pos", longint'(out2), 32767);
    end
    // Negative saturation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(i % 4 == 0, 1, -32768);
      if (i == 3) check("sat_neg", longint'(out2), -32768);
    end

    // Bypass while a sample is pending: no overrun, older sample dropped
    do_reset();
    cyc(1, 0, 3);
    cyc(1, 1, 4);
    check("bypass_no_ovr", longint'(ovr1), 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("bypass_drop", longint'(out1), 4);

    // Overrun: 5 overwritten by 7, then bypass 9
    do_reset();
    cyc(1, 0, 5);
    cyc(1, 0, 7);
    check("overrun_set", longint'(ovr2), 1);
    cyc(0, 1, 0);
    cyc(1, 1, 9);
    check("overrun_used7", longint'(out1), 7);
    cyc(0, 1, 0);
    check("overrun_sum", longint'(out1), 16);
    check("overrun_sticky", longint'(ovr2), 1);

    // Irregular strobes with pending-path use and gaps
    do_reset();
    for (int i = 0; i < 40; i++)
      cyc(i % 3 == 0, (i % 5 == 2) || (i % 7 == 0), i * 37 - 500);

    // Reset mid-ramp with a pending sample and overrun set
    do_reset();
    for (int i = 0; i < 6; i++) cyc(i == 0, 1, 1);
    cyc(1, 0, 55);
    cyc(1, 0, 56);
    rst_n = 1'b0;
    cyc(0, 1, 0);
    check("midrst_out", longint'(out2), 0);
    check("midrst_ovr", longint'(ovr2), 0);
    check("midrst_stb", longint'(stb2), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    check("midrst_lost", longint'(out2), 0);
    check("midrst_lost1", longint'(out1), 0);

    cyc(0, 0, 0);
    @(negedge clk);
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
